// File: rtl/xor5_frame_checker.sv
// xor5_frame_checker: folds per-word odd parity over a frame of FRAME_LEN
// 5-bit words, compares it with a trailing check word, and reports one
// result per frame over a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// COLLECT | accepting data words, accumulating parity into acc
// CHECK   | next accepted word is the check word; result is registered
// REPORT  | result presented on out_*, input stalled until out_ready
module xor5_frame_checker #(
  parameter int FRAME_LEN = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_parity,
  output logic                 out_err,
  output logic                 out_fmt_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t           state;
  logic             acc;
  logic [IDX_W-1:0] idx;
  logic             word_xfer;
  logic             res_xfer;
  logic             fmt_bad;

  // in_ready depends on state only, so upstream never sees a combinational loop
  assign in_ready  = (state != REPORT);
  assign word_xfer = in_valid && in_ready;
  assign res_xfer  = out_valid && out_ready;
  assign fmt_bad   = |in_data[4:1];

  // frame sequencing, parity accumulation and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      acc         <= 1'b0;
      idx         <= '0;
      out_valid   <= 1'b0;
      out_parity  <= 1'b0;
      out_err     <= 1'b0;
      out_fmt_err <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (word_xfer) begin
            acc <= acc ^ (^in_data);
            // idx parks at the last position until the result is taken
            if (idx == IDX_LAST) begin
              state <= CHECK;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        CHECK: begin
          if (word_xfer) begin
            out_parity  <= acc;
            out_fmt_err <= fmt_bad;
            out_err     <= (acc != in_data[0]) | fmt_bad;
            out_valid   <= 1'b1;
            state       <= REPORT;
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= 1'b0;
            idx       <= '0;
            state     <= COLLECT;
          end
        end
        default: begin
          state     <= COLLECT;
          out_valid <= 1'b0;
          acc       <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

  // saturating count of errored frames; clear has priority over increment
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_count <= '0;
    end else if (res_xfer && out_err && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xor5_frame_checker.sv
// Scoreboard bench for xor5_frame_checker with FRAME_LEN=4, ERR_CNT_W=2.
module tb_xor5_frame_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_parity;
  logic       out_err;
  logic       out_fmt_err;
  logic       err_clr;
  logic [1:0] err_count;

  typedef struct packed {
    logic p;
    logic e;
    logic f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  xor5_frame_checker #(.FRAME_LEN(4), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_err(out_err), .out_fmt_err(out_fmt_err),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // monitor: pop the expected result whenever a result handshake is seen
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 8'd1, 8'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_parity", {7'd0, out_parity}, {7'd0, e.p});
        chk("out_err", {7'd0, out_err}, {7'd0, e.e});
        chk("out_fmt_err", {7'd0, out_fmt_err}, {7'd0, e.f});
      end
    end
  end

  task automatic send_word(input logic [4:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 8'd1, 8'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 5'h00;
  endtask

  task automatic send_frame(input logic [4:0] w0, w1, w2, w3, ck,
                            input logic p, e, f);
    exp_t x;
    x.p = p; x.e = e; x.f = f;
    exp_q.push_back(x);
    send_word(w0);
    send_word(w1);
    send_word(w2);
    send_word(w3);
    send_word(ck);
    // result must be valid right after the check-word edge
    chk("latency_out_valid", {7'd0, out_valid}, 8'd1);
    chk("report_in_ready", {7'd0, in_ready}, 8'd0);
  endtask

  task automatic wait_handshake();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
    chk({tag, "_out_valid"}, {7'd0, out_valid}, 8'd0);
    chk({tag, "_out_parity"}, {7'd0, out_parity}, 8'd0);
    chk({tag, "_out_err"}, {7'd0, out_err}, 8'd0);
    chk({tag, "_out_fmt_err"}, {7'd0, out_fmt_err}, 8'd0);
    chk({tag, "_err_count"}, {6'd0, err_count}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 5'h00; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", {7'd0, in_ready}, 8'd1);
    chk("reset_out_valid", {7'd0, out_valid}, 8'd0);
    chk("reset_err_count", {6'd0, err_count}, 8'd0);

    // good frame: parities 1,0,1,1 -> 1; check 01
    send_frame(5'h01, 5'h03, 5'h07, 5'h1F, 5'h01, 1'b1, 1'b0, 1'b0);
    wait_handshake();
    chk("good_err_count", {6'd0, err_count}, 8'd0);
    chk("good_after_in_ready", {7'd0, in_ready}, 8'd1);
    chk("good_after_out_valid", {7'd0, out_valid}, 8'd0);

    // parity mismatch
    send_frame(5'h01, 5'h03, 5'h07, 5'h1F, 5'h00, 1'b1, 1'b1, 1'b0);
    wait_handshake();
    chk("mismatch_err_count", {6'd0, err_count}, 8'd1);

    // format error with matching parity bit
    send_frame(5'h01, 5'h03, 5'h07, 5'h1F, 5'h03, 1'b1, 1'b1, 1'b1);
    wait_handshake();
    chk("fmt_err_count", {6'd0, err_count}, 8'd2);

    // backpressure: result held for 10 cycles while upstream offers words
    out_ready = 1'b0;
    send_frame(5'h01, 5'h03, 5'h07, 5'h1F, 5'h01, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 5'h1F;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
      chk("bp_out_valid", {7'd0, out_valid}, 8'd1);
      chk("bp_out_parity", {7'd0, out_parity}, 8'd1);
      chk("bp_out_err", {7'd0, out_err}, 8'd0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_handshake();
    chk("bp_release_in_ready", {7'd0, in_ready}, 8'd1);
    chk("bp_err_count", {6'd0, err_count}, 8'd2);
    // all-even-parity frame right after release; a consumed word would skew it
    send_frame(5'h1E, 5'h11, 5'h18, 5'h0F, 5'h00, 1'b0, 1'b0, 1'b0);
    wait_handshake();

    // reset mid-frame discards the partial frame
    send_word(5'h01);
    send_word(5'h00);
    do_reset("midrst");
    send_frame(5'h1E, 5'h11, 5'h18, 5'h0F, 5'h00, 1'b0, 1'b0, 1'b0);
    wait_handshake();
    chk("midrst_err_count", {6'd0, err_count}, 8'd0);

    // saturation at 3 for a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      send_frame(5'h01, 5'h03, 5'h07, 5'h1F, 5'h00, 1'b1, 1'b1, 1'b0);
      wait_handshake();
      chk("sat_err_count", {6'd0, err_count}, (i < 3) ? 8'(i + 1) : 8'd3);
    end

    // clear wins over a simultaneous increment
    send_frame(5'h01, 5'h03, 5'h07, 5'h1F, 5'h00, 1'b1, 1'b1, 1'b0);
    err_clr = 1'b1;
    wait_handshake();
    err_clr = 1'b0;
    chk("clr_err_count", {6'd0, err_count}, 8'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
